// File: rtl/int_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_source_ctrl
// Purpose  : Interrupt source controller for RV32core. Captures N_SRC request
//            lines into a pending register, masks them with a writable enable
//            mask and dispatches the lowest-index eligible source as a
//            registered pulse on 'interrupter'. It then waits for the core's
//            end-of-interrupt (mret) before dispatching again.
// Ports    : clk          - clock, rising edge
//            rst          - synchronous reset, active low
//            irq_in       - raw request lines, synchronous to clk
//            en_we        - enable mask write strobe
//            en_wdata     - new enable mask value
//            en_mask      - current enable mask
//            pending      - pending register
//            interrupter  - registered interrupt request to the core
//            int_id       - index of the dispatched source
//            int_ack      - core took the trap; ends the pulse early
//            int_eoi      - core executed mret; ends service
//            busy         - high while a dispatch is outstanding
// Config   : INT_SRC_EDGE_EN - defined: rising-edge detection on irq_in;
//                              undefined: level-sensitive capture.
// Revision : 1.0 - initial release
// ============================================================================
module int_source_ctrl #(
  parameter int N_SRC        = 4,
  parameter int ID_W         = 2,
  parameter int PULSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  output logic [N_SRC-1:0] en_mask,
  output logic [N_SRC-1:0] pending,
  output logic             interrupter,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             busy
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_pulse_max = CNT_W'(PULSE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_en_mask;
  logic             r_interrupter;
  logic [ID_W-1:0]  r_int_id;
  logic             r_busy;

  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_win_oh;
  logic [N_SRC-1:0] w_clr;
  logic [ID_W-1:0]  w_win_id;
  logic             w_any;
  logic             w_dispatch;

`ifdef INT_SRC_EDGE_EN
  // Previous-cycle copy of irq_in. Resets to all ones so lines that are
  // already high when reset releases are not seen as new edges.
  logic [N_SRC-1:0] r_irq_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_irq_q <= '1;
    end else begin
      r_irq_q <= irq_in;
    end
  end

  assign w_set = irq_in & ~r_irq_q;
`else
  assign w_set = irq_in;
`endif

  assign w_elig = r_pending & r_en_mask;
  assign w_any  = |w_elig;

  // Fixed priority: scan from the top so the lowest set index is kept last.
  always_comb begin
    w_win_id = '0;
    w_win_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_id = ID_W'(i);
        w_win_oh = N_SRC'(1) << i;
      end
    end
  end

  assign w_dispatch = (r_state == S_IDLE) && w_any;
  assign w_clr      = w_dispatch ? w_win_oh : '0;

  // Pending / enable mask. The set term is OR-ed in after the clear so a
  // same-cycle request on the source being dispatched stays pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
      r_en_mask <= '1;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (en_we) begin
        r_en_mask <= en_wdata;
      end
    end
  end

  // Dispatch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_interrupter <= 1'b0;
      r_int_id      <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state       <= S_REQ;
            r_int_id      <= w_win_id;
            r_interrupter <= 1'b1;
            r_cnt         <= CNT_W'(1);
            r_busy        <= 1'b1;
          end
        end
        S_REQ: begin
          // Ack and expiry together still give one transition.
          if (int_ack || (r_cnt == c_pulse_max)) begin
            r_state       <= S_SERVICE;
            r_interrupter <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SERVICE: begin
          if (int_eoi) begin
            r_state  <= S_IDLE;
            r_int_id <= '0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_interrupter <= 1'b0;
          r_busy        <= 1'b0;
          r_cnt         <= '0;
        end
      endcase
    end
  end

  assign en_mask     = r_en_mask;
  assign pending     = r_pending;
  assign interrupter = r_interrupter;
  assign int_id      = r_int_id;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_int_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_source_ctrl
// Purpose  : Directed self-checking bench for int_source_ctrl (N_SRC=4,
//            ID_W=2, PULSE_CYCLES=2). Inputs change and outputs are sampled
//            1 time unit after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_source_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       en_we;
  logic [3:0] en_wdata;
  logic [3:0] en_mask;
  logic [3:0] pending;
  logic       interrupter;
  logic [1:0] int_id;
  logic       int_ack;
  logic       int_eoi;
  logic       busy;

  int n_pass;
  int n_chk;

  int_source_ctrl #(
    .N_SRC       (4),
    .ID_W        (2),
    .PULSE_CYCLES(2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .en_mask    (en_mask),
    .pending    (pending),
    .interrupter(interrupter),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .int_eoi    (int_eoi),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass   = 0;
    n_chk    = 0;
    rst      = 1'b0;
    irq_in   = 4'b1111;
    en_we    = 1'b0;
    en_wdata = 4'b0000;
    int_ack  = 1'b0;
    int_eoi  = 1'b0;

    // ---------------- reset ----------------
    step();
    step();
    check("rst_interrupter", interrupter, 0);
    check("rst_int_id", int_id, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_en_mask", en_mask, 4'b1111);

`ifdef INT_SRC_EDGE_EN
    // Lines held high through reset release must not dispatch.
    rst = 1'b1;
    step();
    step();
    step();
    check("rel_no_pend", pending, 0);
    check("rel_no_irq", interrupter, 0);
    irq_in = 4'b0000;
    step();
    step();
`else
    irq_in = 4'b0000;
    rst    = 1'b1;
    step();
    step();
    step();
    check("rel_no_pend", pending, 0);
    check("rel_no_irq", interrupter, 0);
`endif

    // ---------------- single source ----------------
    irq_in = 4'b0100;
    step();
    check("single_pend", pending, 4'b0100);
    check("single_lat1", interrupter, 0);
    irq_in = 4'b0000;
    step();
    check("single_irq", interrupter, 1);
    check("single_id", int_id, 2);
    check("single_pclr", pending, 0);
    check("single_busy", busy, 1);
    step();
    check("single_hold", interrupter, 1);
    step();
    check("single_drop", interrupter, 0);
    check("single_svc_busy", busy, 1);
    int_eoi = 1'b1;
    step();
    int_eoi = 1'b0;
    check("single_eoi_busy", busy, 0);
    check("single_eoi_id", int_id, 0);

    // ---------------- priority and early ack ----------------
    irq_in = 4'b1010;
    step();
    check("prio_pend", pending, 4'b1010);
    irq_in = 4'b0000;
    step();
    check("prio_irq", interrupter, 1);
    check("prio_id", int_id, 1);
    check("prio_pend_left", pending, 4'b1000);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("ack_drop", interrupter, 0);
    step();
    check("ack_svc_irq", interrupter, 0);
    check("ack_svc_id", int_id, 1);
    check("ack_svc_busy", busy, 1);
    int_eoi = 1'b1;
    step();
    int_eoi = 1'b0;
    check("prio_eoi_irq", interrupter, 0);
    step();
    check("next_irq", interrupter, 1);
    check("next_id", int_id, 3);
    step();
    step();
    check("next_drop", interrupter, 0);
    int_eoi = 1'b1;
    step();
    int_eoi = 1'b0;

    // ---------------- masking ----------------
    en_we    = 1'b1;
    en_wdata = 4'b1110;
    step();
    en_we = 1'b0;
    check("mask_val", en_mask, 4'b1110);
    irq_in = 4'b0001;
    step();
    irq_in = 4'b0000;
    check("mask_pend", pending, 4'b0001);
    step();
    step();
    check("mask_no_irq", interrupter, 0);
    check("mask_pend_kept", pending, 4'b0001);
    en_we    = 1'b1;
    en_wdata = 4'b1111;
    step();
    en_we = 1'b0;
    check("unmask_wait", interrupter, 0);
    step();
    check("unmask_irq", interrupter, 1);
    check("unmask_id", int_id, 0);
    step();
    // Ack coincides with counter expiry.
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("ackexp_drop", interrupter, 0);
    step();
    check("ackexp_svc", busy, 1);
    check("ackexp_low", interrupter, 0);
    int_eoi = 1'b1;
    step();
    int_eoi = 1'b0;
    check("ackexp_eoi", busy, 0);

    // ---------------- event during service ----------------
    irq_in = 4'b0100;
    step();
    irq_in = 4'b0000;
    step();
    check("svc_irq", interrupter, 1);
    step();
    step();
    check("svc_enter", interrupter, 0);
    irq_in = 4'b0100;
    step();
    irq_in = 4'b0000;
    check("svc_repend", pending, 4'b0100);
    step();
    step();
    check("svc_no_pulse", interrupter, 0);
    check("svc_id_hold", int_id, 2);
    int_eoi = 1'b1;
    step();
    int_eoi = 1'b0;
    check("svc_eoi_busy", busy, 0);
    check("svc_eoi_low", interrupter, 0);
    step();
    check("redisp_irq", interrupter, 1);
    check("redisp_id", int_id, 2);
    check("redisp_pend", pending, 0);
    // EOI during REQ is ignored; also pend source 3.
    int_eoi = 1'b1;
    irq_in  = 4'b1000;
    step();
    int_eoi = 1'b0;
    irq_in  = 4'b0000;
    check("req_eoi_ign", interrupter, 1);
    check("req_busy", busy, 1);
    check("req_pend3", pending, 4'b1000);

    // ---------------- reset mid-REQ ----------------
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_irq", interrupter, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pend", pending, 0);
    check("mid_rst_id", int_id, 0);
    step();
    step();
    check("post_rst_idle", interrupter, 0);

    // New dispatch needs no EOI after the abort. irq_in[1] is held high
    // across the dispatch edge: level mode keeps it pending (set wins).
    irq_in = 4'b0010;
    step();
    check("post_rst_pend", pending, 4'b0010);
    step();
    check("post_rst_irq", interrupter, 1);
    check("post_rst_id", int_id, 1);
`ifdef INT_SRC_EDGE_EN
    check("setwins_pend", pending, 4'b0000);
`else
    check("setwins_pend", pending, 4'b0010);
`endif
    irq_in = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
